// File: rtl/cordic_iter_rot.sv
// cordic_iter_rot: iterative CORDIC rotator producing cos/sin of a signed Q10.12 degree angle.
// Optional macro ANGLE_FOLD_EN widens the accepted range from +/-90 to +/-180 degrees.
module cordic_iter_rot #(
    parameter int WIDTH_INPUT  = 4,
    parameter int WIDTH_OUTPUT = 22,
    parameter int ITER         = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WIDTH_OUTPUT-1:0] angle_in,
    output logic [WIDTH_INPUT-1:0]  tbl_idx,
    input  logic [WIDTH_OUTPUT-1:0] tbl_angle,
    output logic                    busy,
    output logic                    done,
    output logic                    range_err,
    output logic [WIDTH_OUTPUT-1:0] cos_out,
    output logic [WIDTH_OUTPUT-1:0] sin_out
);

    localparam int IW = WIDTH_INPUT + 1;
    localparam int W  = WIDTH_OUTPUT;
    localparam logic [IW-1:0]       ITER_L   = IW'(ITER);
    localparam logic signed [W-1:0] INV_GAIN = W'(32'sd2487);
    localparam logic signed [W-1:0] DEG90    = W'(32'sd368640);
    localparam logic signed [W-1:0] DEG180   = W'(32'sd737280);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic [IW-1:0]          iter_r;
    logic [IW-1:0]          iter_inc_s;
    logic [WIDTH_INPUT-1:0] idx_nxt_s;
    logic signed [W-1:0]    x_r, y_r, z_r;
    logic signed [W-1:0]    angle_s, z_init_s;
    logic signed [W-1:0]    x_sh_s, y_sh_s;
    logic signed [W-1:0]    x_nxt_s, y_nxt_s, z_nxt_s;
    logic signed [W-1:0]    cos_fin_s, sin_fin_s;
    logic signed [W-1:0]    tbl_s;
    logic                   in_range_s;
`ifdef ANGLE_FOLD_EN
    logic                   fold_s;
    logic                   neg_r;
`endif

    assign angle_s = $signed(angle_in);
    assign tbl_s   = $signed(tbl_angle);

    // Range check of the requested angle and the starting residual angle
    always_comb begin
        in_range_s = 1'b0;
        z_init_s   = angle_s;
`ifdef ANGLE_FOLD_EN
        fold_s     = 1'b0;
        if (angle_s > DEG180 || angle_s < -DEG180) begin
            in_range_s = 1'b0;
        end else if (angle_s > DEG90) begin
            // rotate by (angle - 180) and negate the result: cos/sin(a) = -cos/sin(a - 180)
            in_range_s = 1'b1;
            fold_s     = 1'b1;
            z_init_s   = angle_s - DEG180;
        end else if (angle_s < -DEG90) begin
            in_range_s = 1'b1;
            fold_s     = 1'b1;
            z_init_s   = angle_s + DEG180;
        end else begin
            in_range_s = 1'b1;
        end
`else
        if (angle_s > DEG90 || angle_s < -DEG90) begin
            in_range_s = 1'b0;
        end else begin
            in_range_s = 1'b1;
        end
`endif
    end

    // One micro-rotation; direction follows the sign of the residual angle
    always_comb begin
        x_sh_s = x_r >>> iter_r;
        y_sh_s = y_r >>> iter_r;
        if (!z_r[W-1]) begin
            x_nxt_s = x_r - y_sh_s;
            y_nxt_s = y_r + x_sh_s;
            z_nxt_s = z_r - tbl_s;
        end else begin
            x_nxt_s = x_r + y_sh_s;
            y_nxt_s = y_r - x_sh_s;
            z_nxt_s = z_r + tbl_s;
        end
    end

    // Final result selection and next table index
    always_comb begin
`ifdef ANGLE_FOLD_EN
        if (neg_r) begin
            cos_fin_s = -x_r;
            sin_fin_s = -y_r;
        end else begin
            cos_fin_s = x_r;
            sin_fin_s = y_r;
        end
`else
        cos_fin_s = x_r;
        sin_fin_s = y_r;
`endif
        iter_inc_s = iter_r + IW'(32'd1);
        if (iter_inc_s < ITER_L) begin
            idx_nxt_s = iter_inc_s[WIDTH_INPUT-1:0];
        end else begin
            idx_nxt_s = {WIDTH_INPUT{1'b0}};
        end
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            iter_r    <= {IW{1'b0}};
            x_r       <= {W{1'b0}};
            y_r       <= {W{1'b0}};
            z_r       <= {W{1'b0}};
            tbl_idx   <= {WIDTH_INPUT{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
            cos_out   <= {W{1'b0}};
            sin_out   <= {W{1'b0}};
`ifdef ANGLE_FOLD_EN
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done      <= 1'b0;
                    range_err <= 1'b0;
                    tbl_idx   <= {WIDTH_INPUT{1'b0}};
                    if (start) begin
                        busy <= 1'b1;
                        if (in_range_s) begin
                            state_r <= RUN;
                            iter_r  <= {IW{1'b0}};
                            x_r     <= INV_GAIN;
                            y_r     <= {W{1'b0}};
                            z_r     <= z_init_s;
`ifdef ANGLE_FOLD_EN
                            neg_r   <= fold_s;
`endif
                        end else begin
                            state_r   <= DONE;
                            done      <= 1'b1;
                            range_err <= 1'b1;
                            cos_out   <= {W{1'b0}};
                            sin_out   <= {W{1'b0}};
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    // the cycle after the last micro-rotation publishes the result
                    if (iter_r == ITER_L) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        tbl_idx <= {WIDTH_INPUT{1'b0}};
                        cos_out <= cos_fin_s;
                        sin_out <= sin_fin_s;
                    end else begin
                        x_r     <= x_nxt_s;
                        y_r     <= y_nxt_s;
                        z_r     <= z_nxt_s;
                        iter_r  <= iter_inc_s;
                        tbl_idx <= idx_nxt_s;
                    end
                end
                DONE: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    range_err <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    range_err <= 1'b0;
                    tbl_idx   <= {WIDTH_INPUT{1'b0}};
                end
            endcase
        end
    end

endmodule
